// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants: response codes, default widths and the slave FSM state encodings.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 8;
  localparam int unsigned AXI_DATA_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WIdle,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RData
  } r_state_e;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x DATA_W register array with one synchronous write port, one registered read port
// and a synchronous clear.
module reg_bank #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the pre-write contents when both ports hit the same entry on one edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite single-beat register slave: independent AW/W capture, concurrent read channel,
// OKAY/SLVERR responses and a saturating error counter.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [7:0]        err_cnt_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable; the range check uses the full address.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              aw_fire, w_fire, ar_fire;
  logic              wr_commit, wr_ok, rd_ok, wr_err, rd_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] bank_rdata;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;

  // Readys depend only on registered state and reset, never on the valids.
  assign awready_o = !reset_i && (w_state_q == WIdle) && !aw_held_q;
  assign wready_o  = !reset_i && (w_state_q == WIdle) && !w_held_q;
  assign arready_o = !reset_i && (r_state_q == RIdle);

  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign ar_fire   = arvalid_i && arready_o;

  assign wr_addr   = aw_held_q ? awaddr_q : awaddr_i;
  assign wr_data   = w_held_q ? wdata_q : wdata_i;
  assign wr_commit = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign wr_ok     = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_ok     = {1'b0, araddr_i} < DEPTH_EXT;
  assign wr_err    = wr_commit && !wr_ok;
  assign rd_err    = ar_fire && !rd_ok;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      WIdle: begin
        if (wr_commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          w_state_d = WResp;
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr_i;
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = wdata_i;
          end
        end
      end
      WResp: begin
        if (bready_i) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_fire) begin
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          r_state_d = RData;
        end
      end
      RData: begin
        if (rready_i) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    err_inc   = 2'(wr_err) + 2'(rd_err);
    err_sum   = {1'b0, err_cnt_q} + 9'(err_inc);
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      err_cnt_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  reg_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_reg_bank (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (wr_commit && wr_ok),
    .waddr_i (wr_addr[IDX_W-1:0]),
    .wdata_i (wr_data),
    .re_i    (ar_fire && rd_ok),
    .raddr_i (araddr_i[IDX_W-1:0]),
    .rdata_o (bank_rdata)
  );

  assign bvalid_o  = (w_state_q == WResp);
  assign bresp_o   = bresp_q;
  assign rvalid_o  = (r_state_q == RData);
  assign rresp_o   = rresp_q;
  // Error reads return zero; the bank is not read for them.
  assign rdata_o   = (rresp_q == RESP_OKAY) ? bank_rdata : '0;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized self-checking bench for axi_lite_reg_slave against an array/counter reference model.
module tb_axi_lite_reg_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] awaddr, wdata, araddr, rdata;
  logic       awvalid, awready, wvalid, wready, bvalid, bready;
  logic       arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model
  logic [7:0] mem_m [16];
  int         err_m;

  always #5 clk = ~clk;

  axi_lite_reg_slave #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .awaddr_i  (awaddr),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .wdata_i   (wdata),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .bresp_o   (bresp),
    .bvalid_o  (bvalid),
    .bready_i  (bready),
    .araddr_i  (araddr),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .rdata_o   (rdata),
    .rresp_o   (rresp),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .err_cnt_o (err_cnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    err_m = 0;
  endfunction

  function automatic void model_err();
    if (err_m < 255) err_m++;
  endfunction

  // Returns expected write response and applies the write.
  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [7:0] d);
    if (a < 16) begin
      mem_m[a[3:0]] = d;
      return 2'b00;
    end
    model_err();
    return 2'b10;
  endfunction

  function automatic logic [1:0] model_read(input logic [7:0] a, output logic [7:0] d);
    if (a < 16) begin
      d = mem_m[a[3:0]];
      return 2'b00;
    end
    d = 8'h00;
    model_err();
    return 2'b10;
  endfunction

  // Drives one write with AW/W delayed independently; ends on the negedge after the b handshake.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int aw_dly,
                          input int w_dly, output logic [1:0] resp, output int cycles);
    bit aw_done = 0;
    bit w_done  = 0;
    int cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awaddr  = a;
      wdata   = d;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      n_vec++;
      if (bvalid !== 1'b0) begin
        n_miss++;
        $display("FAIL early_bvalid: got %b required 0 (cycle %0d)", bvalid, cyc);
      end
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    cycles  = cyc;
    n_vec++;
    if (!(aw_done && w_done)) begin
      n_miss++;
      $display("FAIL write_handshake_timeout: addr %h not accepted in 50 cycles", a);
    end
    n_vec++;
    if (bvalid !== 1'b1) begin
      n_miss++;
      $display("FAIL bvalid_latency: got %b required 1 one cycle after commit", bvalid);
    end
    resp   = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n_vec++;
    if (bvalid !== 1'b0) begin
      n_miss++;
      $display("FAIL bvalid_clear: got %b required 0", bvalid);
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic [1:0] resp);
    bit done = 0;
    int cyc  = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!done && cyc < 50) begin
      if (arready) done = 1;
      @(negedge clk);
      cyc++;
    end
    arvalid = 1'b0;
    n_vec++;
    if (!done) begin
      n_miss++;
      $display("FAIL read_handshake_timeout: addr %h not accepted in 50 cycles", a);
    end
    n_vec++;
    if (rvalid !== 1'b1) begin
      n_miss++;
      $display("FAIL rvalid_latency: got %b required 1", rvalid);
    end
    d      = rdata;
    resp   = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_miss++;
      $display("FAIL rvalid_clear: got %b required 0", rvalid);
    end
  endtask

  task automatic check_write(input logic [7:0] a, input logic [7:0] d, input int aw_dly,
                             input int w_dly);
    logic [1:0] resp, exp;
    int         cycles;
    do_write(a, d, aw_dly, w_dly, resp, cycles);
    exp = model_write(a, d);
    n_vec++;
    if (resp !== exp) begin
      n_miss++;
      $display("FAIL bresp: addr %h got %b required %b", a, resp, exp);
    end
    n_vec++;
    if (err_cnt !== 8'(err_m)) begin
      n_miss++;
      $display("FAIL err_cnt_after_write: got %0d required %0d", err_cnt, err_m);
    end
  endtask

  task automatic check_read(input logic [7:0] a);
    logic [7:0] d, exp_d;
    logic [1:0] resp, exp;
    do_read(a, d, resp);
    exp = model_read(a, exp_d);
    n_vec++;
    if (resp !== exp || d !== exp_d) begin
      n_miss++;
      $display("FAIL read: addr %h got data %h resp %b required data %h resp %b",
               a, d, resp, exp_d, exp);
    end
    n_vec++;
    if (err_cnt !== 8'(err_m)) begin
      n_miss++;
      $display("FAIL err_cnt_after_read: got %0d required %0d", err_cnt, err_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_miss++;
      $display("FAIL reset_handshakes: got %b required 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    n_vec++;
    if ({bresp, rresp, rdata, err_cnt} !== 20'h0) begin
      n_miss++;
      $display("FAIL reset_outputs: bresp %b rresp %b rdata %h err_cnt %h required all 0",
               bresp, rresp, rdata, err_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_miss++;
      $display("FAIL readys_after_reset: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle_write();
    check_write(8'h03, 8'hA5, 0, 0);
    check_read(8'h03);
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    int         cycles;
    do_write(8'h07, 8'h3C, 3, 0, resp, cycles);
    void'(model_write(8'h07, 8'h3C));
    n_vec++;
    if (cycles !== 4 || resp !== 2'b00) begin
      n_miss++;
      $display("FAIL w_then_aw: cycles to commit %0d resp %b required 4 and 00", cycles, resp);
    end
    check_read(8'h07);
  endtask

  task automatic test_errors();
    check_write(8'h20, 8'h5A, 0, 0);
    check_read(8'hFF);
    check_read(8'h10);
    check_read(8'h0F);
    check_read(8'h00);
    check_write(8'h10, 8'h77, 1, 0);
    check_read(8'h03);
  endtask

  task automatic test_stall();
    logic [7:0] d0, exp_d;
    logic [1:0] b0, r0, exp_r;
    awaddr = 8'h09; wdata = 8'hC3; araddr = 8'h09;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_r = model_read(8'h09, exp_d);
    void'(model_write(8'h09, 8'hC3));
    b0 = bresp; r0 = rresp; d0 = rdata;
    n_vec++;
    if (d0 !== exp_d || r0 !== exp_r || b0 !== 2'b00) begin
      n_miss++;
      $display("FAIL stall_start: rdata %h rresp %b bresp %b required %h %b 00",
               d0, r0, b0, exp_d, exp_r);
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({bvalid, rvalid, awready, wready, arready} !== 5'b11000 ||
          bresp !== b0 || rresp !== r0 || rdata !== d0) begin
        n_miss++;
        $display("FAIL stall_hold: cycle %0d valids/readys %b rdata %h required 11000 %h",
                 i, {bvalid, rvalid, awready, wready, arready}, rdata, d0);
      end
      @(negedge clk);
    end
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    n_vec++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      n_miss++;
      $display("FAIL stall_release: got %b required 00111",
               {bvalid, rvalid, awready, wready, arready});
    end
    check_read(8'h09);
  endtask

  task automatic test_collision();
    logic [7:0] exp_d;
    logic [1:0] exp_r;
    awaddr = 8'h05; wdata = 8'h11; araddr = 8'h05;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_r = model_read(8'h05, exp_d);
    void'(model_write(8'h05, 8'h11));
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || bvalid !== 1'b1) begin
      n_miss++;
      $display("FAIL collision: rvalid %b rdata %h bvalid %b required 1 %h 1",
               rvalid, rdata, bvalid, exp_d);
    end
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    check_read(8'h05);
  endtask

  task automatic test_reset_mid();
    wdata = 8'hEE; wvalid = 1; araddr = 8'h03; arvalid = 1;
    @(negedge clk);
    wvalid = 0; arvalid = 0;
    n_vec++;
    if (wready !== 1'b0 || rvalid !== 1'b1) begin
      n_miss++;
      $display("FAIL pre_reset: wready %b rvalid %b required 0 1", wready, rvalid);
    end
    reset = 1;
    @(negedge clk);
    model_reset();
    n_vec++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0 || err_cnt !== 8'h00) begin
      n_miss++;
      $display("FAIL mid_reset: valids/readys %b err_cnt %h required 00000 00",
               {bvalid, rvalid, awready, wready, arready}, err_cnt);
    end
    reset = 0;
    @(negedge clk);
    n_vec++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      n_miss++;
      $display("FAIL post_reset: got %b required 00111",
               {bvalid, rvalid, awready, wready, arready});
    end
    check_read(8'h03);
    check_read(8'h09);
    // AW leads: a stale held W would commit early with 0xEE.
    check_write(8'h0C, 8'h4B, 0, 2);
    check_read(8'h0C);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 80; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 0)
        check_write(a, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        check_read(a);
    end
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 130; i++) begin
      check_write(8'($urandom_range(16, 255)), 8'($urandom), 0, 0);
      check_read(8'($urandom_range(16, 255)));
    end
    n_vec++;
    if (err_cnt !== 8'hFF) begin
      n_miss++;
      $display("FAIL err_saturate: got %0d required 255", err_cnt);
    end
    check_read(8'h0C);
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_errors();
    test_stall();
    test_collision();
    test_reset_mid();
    test_back_to_back_random();
    test_err_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
